adau1761_cfg_seq: RTL and testbench

ADAU1761_CFG_SEQ -- requirements
Module: adau1761_cfg_seq

---
 rtl/adau1761_cfg_seq_if.sv | 47 ++++
 rtl/adau1761_cfg_seq.sv | 196 +++++++++++++++++++
 tb/tb_adau1761_cfg_seq.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adau1761_cfg_seq_if.sv
// AXI4-Lite master bundle used by the ADAU1761 configuration sequencer.
// Write and read channels only; no IDs, no bursts.
interface adau1761_cfg_seq_if;
  logic [3:0]  M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [3:0]  M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/adau1761_cfg_seq.sv
// ADAU1761 register-table sequencer: writes every table entry over
// AXI4-Lite, optionally reads each back and compares, with timeouts.
module adau1761_cfg_seq #(
  parameter int NUM_ENTRIES    = 4,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IDX_W =
    (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             start,
  input  logic             verify_en,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [3:0]       tbl_addr,
  input  logic [31:0]      tbl_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  adau1761_cfg_seq_if.master m_axi
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_ENTRIES - 1);

  localparam logic [1:0] E_NONE = 2'd0;
  localparam logic [1:0] E_RESP = 2'd1;
  localparam logic [1:0] E_CMP  = 2'd2;
  localparam logic [1:0] E_TMO  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WB, S_RA, S_RD, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             verify_q, verify_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             awdone_q, awdone_d;
  logic             wdone_q, wdone_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic awvalid, wvalid, arvalid;
  logic aw_hs, w_hs, tmo_hit;

  // VALIDs come only from registered state, never from READY.
  // tbl_idx is registered and only changes on a state change, so
  // the table lookup stays stable for the whole VALID window.
  assign awvalid = (state_q == S_WR) && !awdone_q;
  assign wvalid  = (state_q == S_WR) && !wdone_q;
  assign arvalid = (state_q == S_RA);
  assign aw_hs   = awvalid && m_axi.M_AXI_AWREADY;
  assign w_hs    = wvalid && m_axi.M_AXI_WREADY;
  assign tmo_hit = (tmo_q == TMO_LAST);

  assign m_axi.M_AXI_AWVALID = awvalid;
  assign m_axi.M_AXI_AWADDR  = awvalid ? tbl_addr : 4'h0;
  assign m_axi.M_AXI_WVALID  = wvalid;
  assign m_axi.M_AXI_WDATA   = wvalid ? tbl_data : 32'h0;
  assign m_axi.M_AXI_WSTRB   = 4'hF;
  assign m_axi.M_AXI_BREADY  = (state_q == S_WB);
  assign m_axi.M_AXI_ARVALID = arvalid;
  assign m_axi.M_AXI_ARADDR  = arvalid ? tbl_addr : 4'h0;
  assign m_axi.M_AXI_RREADY  = (state_q == S_RD);

  assign tbl_idx  = idx_q;
  assign busy     = (state_q == S_WR) || (state_q == S_WB) ||
                    (state_q == S_RA) || (state_q == S_RD);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign err_code = code_q;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      verify_q <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= E_NONE;
      awdone_q <= 1'b0;
      wdone_q  <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      verify_q <= verify_d;
      err_q    <= err_d;
      code_q   <= code_d;
      awdone_q <= awdone_d;
      wdone_q  <= wdone_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state logic; the timeout counter restarts on every state change.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    verify_d = verify_q;
    err_d    = err_q;
    code_d   = code_q;
    awdone_d = awdone_q;
    wdone_d  = wdone_q;
    tmo_d    = tmo_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_WR;
          idx_d    = '0;
          err_d    = 1'b0;
          code_d   = E_NONE;
          verify_d = verify_en;
          awdone_d = 1'b0;
          wdone_d  = 1'b0;
        end
      end
      S_WR: begin
        if (aw_hs) awdone_d = 1'b1;
        if (w_hs)  wdone_d  = 1'b1;
        if (awdone_d && wdone_d) begin
          state_d  = S_WB;
          awdone_d = 1'b0;
          wdone_d  = 1'b0;
        end else if (tmo_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = E_TMO;
        end
      end
      S_WB: begin
        if (m_axi.M_AXI_BVALID) begin
          if (m_axi.M_AXI_BRESP != 2'b00) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = E_RESP;
          end else if (idx_q == IDX_LAST) begin
            if (verify_q) begin
              state_d = S_RA;
              idx_d   = '0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            state_d = S_WR;
            idx_d   = idx_q + 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = E_TMO;
        end
      end
      S_RA: begin
        if (m_axi.M_AXI_ARREADY) begin
          state_d = S_RD;
        end else if (tmo_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = E_TMO;
        end
      end
      S_RD: begin
        if (m_axi.M_AXI_RVALID) begin
          if (m_axi.M_AXI_RRESP != 2'b00) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = E_RESP;
          end else if (m_axi.M_AXI_RDATA != tbl_data) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = E_CMP;
          end else if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RA;
            idx_d   = idx_q + 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = E_TMO;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q || state_q == S_IDLE) tmo_d = '0;
  end

endmodule

// File: tb/tb_adau1761_cfg_seq.sv
// Directed bench for adau1761_cfg_seq with a small AXI4-Lite slave
// model (register memory, injectable delays, errors and stalls).
module tb_adau1761_cfg_seq;

  logic        ACLK;
  logic        ARESET;
  logic        start;
  logic        verify_en;
  logic [1:0]  tbl_idx;
  logic [3:0]  tbl_addr;
  logic [31:0] tbl_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  adau1761_cfg_seq_if ax ();

  adau1761_cfg_seq #(
    .NUM_ENTRIES(4),
    .TIMEOUT_CYCLES(256)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .start(start),
    .verify_en(verify_en),
    .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr),
    .tbl_data(tbl_data),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code),
    .m_axi(ax)
  );

  int errors = 0;
  int checks = 0;

  // slave configuration, written only by the test sequence
  int aw_delay  = 0;
  int bad_b_idx = -1;
  int bad_r_idx = -1;
  bit ar_never  = 0;

  // handshake bookkeeping, written only at posedge
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit b_hs = 0, r_hs = 0;
  logic [3:0]  aw_a = '0;
  logic [3:0]  ar_a = '0;
  logic [31:0] w_d  = '0;

  // slave-side state, written only at negedge
  int aw_wait = 0, aw_base = 0, w_base = 0, r_base = 0;
  int done_cnt = 0;
  logic [31:0] mem [4] = '{default: 32'h0};

  int aw0, w0, ar0, r0, dn0;

  // table: entry i -> address 4*i, value i+1
  always_comb begin
    tbl_addr = {tbl_idx, 2'b00};
    tbl_data = 32'(tbl_idx) + 32'd1;
  end

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    b_hs = ax.M_AXI_BVALID && ax.M_AXI_BREADY;
    r_hs = ax.M_AXI_RVALID && ax.M_AXI_RREADY;
    if (ax.M_AXI_AWVALID && ax.M_AXI_AWREADY) begin
      aw_cnt++;
      aw_a = ax.M_AXI_AWADDR;
    end
    if (ax.M_AXI_WVALID && ax.M_AXI_WREADY) begin
      w_cnt++;
      w_d = ax.M_AXI_WDATA;
    end
    if (ax.M_AXI_ARVALID && ax.M_AXI_ARREADY) begin
      ar_cnt++;
      ar_a = ax.M_AXI_ARADDR;
    end
    if (r_hs) r_cnt++;
  end

  always @(negedge ACLK) begin
    if (ARESET) begin
      ax.M_AXI_AWREADY = 1'b0;
      ax.M_AXI_WREADY  = 1'b0;
      ax.M_AXI_BVALID  = 1'b0;
      ax.M_AXI_BRESP   = 2'b00;
      ax.M_AXI_ARREADY = 1'b0;
      ax.M_AXI_RVALID  = 1'b0;
      ax.M_AXI_RDATA   = 32'h0;
      ax.M_AXI_RRESP   = 2'b00;
      aw_wait = 0;
      aw_base = aw_cnt;
      w_base  = w_cnt;
      r_base  = ar_cnt;
    end else begin
      if (ax.M_AXI_AWVALID) begin
        if (aw_wait >= aw_delay) ax.M_AXI_AWREADY = 1'b1;
        else begin
          ax.M_AXI_AWREADY = 1'b0;
          aw_wait++;
        end
      end else begin
        ax.M_AXI_AWREADY = 1'b0;
        aw_wait = 0;
      end
      ax.M_AXI_WREADY = ax.M_AXI_WVALID;
      if (b_hs) ax.M_AXI_BVALID = 1'b0;
      if (!ax.M_AXI_BVALID && aw_cnt > aw_base && w_cnt > w_base) begin
        mem[aw_a[3:2]] = w_d;
        ax.M_AXI_BRESP = (int'(aw_a[3:2]) == bad_b_idx) ? 2'b10 : 2'b00;
        ax.M_AXI_BVALID = 1'b1;
        aw_base++;
        w_base++;
      end
      ax.M_AXI_ARREADY = ax.M_AXI_ARVALID && !ar_never;
      if (r_hs) ax.M_AXI_RVALID = 1'b0;
      if (!ax.M_AXI_RVALID && ar_cnt > r_base) begin
        ax.M_AXI_RDATA = (int'(ar_a[3:2]) == bad_r_idx) ?
                         32'h0000DEAD : mem[ar_a[3:2]];
        ax.M_AXI_RRESP  = 2'b00;
        ax.M_AXI_RVALID = 1'b1;
        r_base++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic snap();
    aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt; r0 = r_cnt; dn0 = done_cnt;
  endtask

  task automatic pulse_start(input logic v);
    @(negedge ACLK);
    start = 1'b1;
    verify_en = v;
    @(posedge ACLK);
    #1;
    start = 1'b0;
    verify_en = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge ACLK);
      if (done || err) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [13:0] v;
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    #1;
    v = {busy, done, err, err_code, tbl_idx, ax.M_AXI_AWVALID,
         ax.M_AXI_WVALID, ax.M_AXI_BREADY, ax.M_AXI_ARVALID,
         ax.M_AXI_RREADY, 3'b000};
    checks++;
    if (v !== 14'h0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 0", v);
    end
    checks++;
    if (ax.M_AXI_WSTRB !== 4'hF) begin
      errors++;
      $display("FAIL wstrb: got %h expected f", ax.M_AXI_WSTRB);
    end
    @(negedge ACLK);
    ARESET = 1'b0;
    repeat (3) @(negedge ACLK);
    v = {busy, done, err, err_code, tbl_idx, ax.M_AXI_AWVALID,
         ax.M_AXI_WVALID, ax.M_AXI_BREADY, ax.M_AXI_ARVALID,
         ax.M_AXI_RREADY, 3'b000};
    checks++;
    if (v !== 14'h0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h expected 0", v);
    end
  endtask

  task automatic test_full_verify();
    bit to;
    logic [37:0] v;
    bit mem_ok;
    snap();
    pulse_start(1'b1);
    v = {ax.M_AXI_AWVALID, busy, ax.M_AXI_AWADDR, ax.M_AXI_WDATA};
    checks++;
    if (v !== {1'b1, 1'b1, 4'h0, 32'h1}) begin
      errors++;
      $display("FAIL start_latency: got %h expected %h",
               v, {1'b1, 1'b1, 4'h0, 32'h1});
    end
    wait_end(300, to);
    checks++;
    if (to || !done || err) begin
      errors++;
      $display("FAIL full_end: to=%0b done=%0b err=%0b expected 0 1 0",
               to, done, err);
    end
    repeat (2) @(negedge ACLK);
    checks++;
    if (aw_cnt - aw0 != 4 || w_cnt - w0 != 4 ||
        ar_cnt - ar0 != 4 || r_cnt - r0 != 4) begin
      errors++;
      $display("FAIL full_counts: got aw=%0d w=%0d ar=%0d r=%0d expected 4 4 4 4",
               aw_cnt - aw0, w_cnt - w0, ar_cnt - ar0, r_cnt - r0);
    end
    checks++;
    if (done_cnt - dn0 != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL full_done_pulse: got pulses=%0d err=%0b expected 1 0",
               done_cnt - dn0, err);
    end
    mem_ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (mem[i] !== 32'(i + 1)) mem_ok = 1'b0;
    checks++;
    if (!mem_ok) begin
      errors++;
      $display("FAIL full_mem: got %h %h %h %h expected 1 2 3 4",
               mem[0], mem[1], mem[2], mem[3]);
    end
  endtask

  task automatic test_aw_delay();
    bit to;
    bit stable;
    int awc, wvc;
    aw_delay = 3;
    snap();
    pulse_start(1'b0);
    awc = 0; wvc = 0; stable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge ACLK);
      if (ax.M_AXI_BREADY) break;
      if (ax.M_AXI_AWVALID) begin
        awc++;
        if (ax.M_AXI_AWADDR !== 4'h0) stable = 1'b0;
      end
      if (ax.M_AXI_WVALID) wvc++;
    end
    checks++;
    if (awc != 4 || !stable) begin
      errors++;
      $display("FAIL aw_hold: got cycles=%0d stable=%0b expected 4 1",
               awc, stable);
    end
    checks++;
    if (wvc != 1) begin
      errors++;
      $display("FAIL w_drop: got cycles=%0d expected 1", wvc);
    end
    checks++;
    if (aw_cnt - aw0 != 1 || w_cnt - w0 != 1) begin
      errors++;
      $display("FAIL single_write: got aw=%0d w=%0d expected 1 1",
               aw_cnt - aw0, w_cnt - w0);
    end
    wait_end(300, to);
    repeat (2) @(negedge ACLK);
    checks++;
    if (to || aw_cnt - aw0 != 4 || ar_cnt - ar0 != 0 ||
        done_cnt - dn0 != 1) begin
      errors++;
      $display("FAIL noverify_run: got to=%0b aw=%0d ar=%0d done=%0d expected 0 4 0 1",
               to, aw_cnt - aw0, ar_cnt - ar0, done_cnt - dn0);
    end
    aw_delay = 0;
  endtask

  task automatic test_bresp_err();
    bit to;
    logic [5:0] v;
    bad_b_idx = 2;
    snap();
    pulse_start(1'b1);
    wait_end(300, to);
    v = {err, err_code, tbl_idx, busy};
    checks++;
    if (to || v !== {1'b1, 2'd1, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL bresp_err: got to=%0b err/code/idx/busy=%b expected 0 1_01_10_0",
               to, v);
    end
    repeat (6) @(negedge ACLK);
    v = {err, err_code, tbl_idx, busy};
    checks++;
    if (aw_cnt - aw0 != 3 || done_cnt - dn0 != 0 ||
        ar_cnt - ar0 != 0 || v !== {1'b1, 2'd1, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL bresp_after: got aw=%0d done=%0d ar=%0d flags=%b expected 3 0 0 101100",
               aw_cnt - aw0, done_cnt - dn0, ar_cnt - ar0, v);
    end
    bad_b_idx = -1;
  endtask

  task automatic test_readback_mismatch();
    bit to;
    logic [4:0] v;
    bad_r_idx = 1;
    snap();
    pulse_start(1'b1);
    wait_end(300, to);
    v = {err, err_code, tbl_idx};
    checks++;
    if (to || v !== {1'b1, 2'd2, 2'd1}) begin
      errors++;
      $display("FAIL mismatch: got to=%0b err/code/idx=%b expected 0 1_10_01",
               to, v);
    end
    repeat (4) @(negedge ACLK);
    checks++;
    if (done_cnt - dn0 != 0 || aw_cnt - aw0 != 4 ||
        ar_cnt - ar0 != 2) begin
      errors++;
      $display("FAIL mismatch_after: got done=%0d aw=%0d ar=%0d expected 0 4 2",
               done_cnt - dn0, aw_cnt - aw0, ar_cnt - ar0);
    end
    bad_r_idx = -1;
  endtask

  task automatic test_back_to_back();
    bit to;
    snap();
    pulse_start(1'b0);
    checks++;
    if ({err, err_code} !== 3'b000) begin
      errors++;
      $display("FAIL err_clear: got err=%0b code=%0d expected 0 0",
               err, err_code);
    end
    repeat (3) @(negedge ACLK);
    pulse_start(1'b1);
    wait_end(300, to);
    repeat (2) @(negedge ACLK);
    checks++;
    if (to || aw_cnt - aw0 != 4 || ar_cnt - ar0 != 0 ||
        done_cnt - dn0 != 1) begin
      errors++;
      $display("FAIL busy_start_ignored: got to=%0b aw=%0d ar=%0d done=%0d expected 0 4 0 1",
               to, aw_cnt - aw0, ar_cnt - ar0, done_cnt - dn0);
    end
    snap();
    pulse_start(1'b1);
    wait_end(300, to);
    repeat (2) @(negedge ACLK);
    checks++;
    if (to || aw_cnt - aw0 != 4 || ar_cnt - ar0 != 4 ||
        done_cnt - dn0 != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: got to=%0b aw=%0d ar=%0d done=%0d err=%0b expected 0 4 4 1 0",
               to, aw_cnt - aw0, ar_cnt - ar0, done_cnt - dn0, err);
    end
  endtask

  task automatic test_ar_timeout();
    bit seen;
    int n;
    logic [6:0] v;
    ar_never = 1'b1;
    pulse_start(1'b1);
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge ACLK);
      if (ax.M_AXI_ARVALID) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ra_entry: got no ARVALID expected ARVALID");
    end
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge ACLK);
      n++;
      if (err) break;
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d expected 256", n);
    end
    v = {err_code, ax.M_AXI_ARVALID, ax.M_AXI_RREADY, tbl_idx, busy};
    checks++;
    if (v !== {2'd3, 1'b0, 1'b0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_state: got code/arv/rr/idx/busy=%b expected 11_0_0_00_0",
               v);
    end
    ar_never = 1'b0;
    repeat (2) @(negedge ACLK);
  endtask

  task automatic test_reset_mid();
    bit to;
    logic [48:0] v;
    aw_delay = 10;
    pulse_start(1'b0);
    repeat (3) @(negedge ACLK);
    checks++;
    if (ax.M_AXI_AWVALID !== 1'b1) begin
      errors++;
      $display("FAIL mid_wr: got AWVALID=%0b expected 1", ax.M_AXI_AWVALID);
    end
    ARESET = 1'b1;
    #1;
    v = {busy, done, err, err_code, tbl_idx, ax.M_AXI_AWVALID,
         ax.M_AXI_WVALID, ax.M_AXI_BREADY, ax.M_AXI_ARVALID,
         ax.M_AXI_RREADY, ax.M_AXI_AWADDR, ax.M_AXI_WDATA};
    checks++;
    if (v !== 49'h0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", v);
    end
    repeat (2) @(negedge ACLK);
    aw_delay = 0;
    snap();
    ARESET = 1'b0;
    start = 1'b1;
    verify_en = 1'b1;
    @(posedge ACLK);
    #1;
    start = 1'b0;
    verify_en = 1'b0;
    checks++;
    if ({ax.M_AXI_AWVALID, busy} !== 2'b11) begin
      errors++;
      $display("FAIL start_after_release: got awvalid/busy=%b expected 11",
               {ax.M_AXI_AWVALID, busy});
    end
    wait_end(300, to);
    repeat (2) @(negedge ACLK);
    checks++;
    if (to || aw_cnt - aw0 != 4 || ar_cnt - ar0 != 4 ||
        done_cnt - dn0 != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL run_after_reset: got to=%0b aw=%0d ar=%0d done=%0d err=%0b expected 0 4 4 1 0",
               to, aw_cnt - aw0, ar_cnt - ar0, done_cnt - dn0, err);
    end
  endtask

  initial begin
    ARESET = 1'b1;
    start = 1'b0;
    verify_en = 1'b0;
    test_reset();
    test_full_verify();
    test_aw_delay();
    test_bresp_err();
    test_readback_mismatch();
    test_back_to_back();
    test_ar_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
